// File: rtl/mmcm_test_pkg.sv
// Shared constants and helpers for the MMCM servo clock test block.
`timescale 1ns/1ps
package mmcm_test_pkg;

  // Default build: ~10 MHz master tone from a 300 MHz clock, 1024-clk slave hold-off.
  localparam int              DEF_ACC_W     = 32;
  localparam longint unsigned DEF_PHASE_INC = 64'd143165577;
  localparam int              DEF_START_DLY = 1024;

  // Rounded NCO increment for a wanted output frequency:
  // inc = round(f_out * 2^acc_w / f_clk). Intended for elaboration-time use.
  function automatic longint unsigned phase_inc(input real f_out_hz,
                                                input real f_clk_hz,
                                                input int  acc_w);
    real scaled;
    scaled = f_out_hz * (2.0 ** acc_w) / f_clk_hz;
    // Real-to-integer casts round to nearest.
    return longint'(scaled);
  endfunction

endpackage

// File: rtl/mmcm_nco.sv
// Phase-accumulator NCO: the registered accumulator MSB is the output tone.
`timescale 1ns/1ps
module mmcm_nco
  import mmcm_test_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ACC_W-1:0] inc,
  output logic             msb
);

  logic [ACC_W-1:0] acc_reg;
  logic             msb_reg;

  // Accumulate modulo 2^ACC_W (carry dropped); the output register samples the MSB
  // of the accumulator value present before this edge's update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
      msb_reg <= 1'b0;
    end else begin
      acc_reg <= acc_reg + inc;
      msb_reg <= acc_reg[ACC_W-1];
    end
  end

  assign msb = msb_reg;

endmodule

// File: rtl/mmcm_slave_test.sv
// Board clock test: NCO master tone plus a delayed-enable forward of the 156.25 MHz reference.
`timescale 1ns/1ps
module mmcm_slave_test
  import mmcm_test_pkg::*;
#(
  parameter int              ACC_W     = DEF_ACC_W,
  parameter longint unsigned PHASE_INC = DEF_PHASE_INC,
  parameter int              START_DLY = DEF_START_DLY
) (
  input  logic clk_in_300Mhz_p,
  input  logic clk_in_300Mhz_n,
  input  logic reset_in,
  input  logic clk_in_156_25_mhz_p,
  input  logic clk_in_156_25_mhz_n,
  output logic user_sma_master_sig,
  output logic user_sma_slave_sig
);

  localparam int               CNT_W   = $clog2(START_DLY + 1);
  localparam logic [CNT_W-1:0] DLY_MAX = CNT_W'(START_DLY);
  localparam logic [ACC_W-1:0] INC     = PHASE_INC[ACC_W-1:0];

  // The positive leg is the clock; the negative leg only matters to a vendor
  // differential buffer, which would produce the same single-ended clock.
  logic clk;
  logic unused_clk_n;
  assign clk          = clk_in_300Mhz_p;
  assign unused_clk_n = clk_in_300Mhz_n;

  // Behavioural differential receive of the reference; it never clocks a flop.
  logic ref_clk;
  assign ref_clk = clk_in_156_25_mhz_p & ~clk_in_156_25_mhz_n;

  logic rst_meta_reg;
  logic rst_s_reg;
  logic rst_s;

  // Reset synchronizer: asserts with reset_in, releases on the 2nd clk edge after it falls.
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      rst_meta_reg <= 1'b1;
      rst_s_reg    <= 1'b1;
    end else begin
      rst_meta_reg <= 1'b0;
      rst_s_reg    <= rst_meta_reg;
    end
  end

  assign rst_s = rst_s_reg;

  mmcm_nco #(
    .ACC_W (ACC_W)
  ) u_nco (
    .clk (clk),
    .rst (rst_s),
    .inc (INC),
    .msb (user_sma_master_sig)
  );

  logic [CNT_W-1:0] dly_cnt_reg;
  logic             slave_en_reg;

  // Start-delay counter: counts up to START_DLY after reset release, then holds.
  always_ff @(posedge clk or posedge rst_s) begin
    if (rst_s) begin
      dly_cnt_reg <= '0;
    end else if (dly_cnt_reg < DLY_MAX) begin
      dly_cnt_reg <= dly_cnt_reg + 1'b1;
    end
  end

  // Slave enable goes high one clk after the counter reaches its terminal value.
  always_ff @(posedge clk or posedge rst_s) begin
    if (rst_s) begin
      slave_en_reg <= 1'b0;
    end else begin
      slave_en_reg <= (dly_cnt_reg == DLY_MAX);
    end
  end

  // Gated reference; runt pulses at enable edges are acceptable on a test output.
  assign user_sma_slave_sig = ref_clk & slave_en_reg;

endmodule

// File: tb/tb_mmcm_slave_test.sv
// Directed bench for mmcm_slave_test: default build plus a 150 MHz / short-delay build.
`timescale 1ns/1ps
module tb_mmcm_slave_test;
  import mmcm_test_pkg::*;

  logic clk_p, clk_n;
  logic ref_osc, ref_force;
  logic ref_p, ref_n;
  logic reset_in;
  logic master_d, slave_d;
  logic master_f, slave_f;

  int n_vec = 0;
  int n_err = 0;

  // 300 MHz complementary pair.
  initial begin
    clk_p = 1'b0;
    clk_n = 1'b1;
    forever begin
      #1.667;
      clk_p = ~clk_p;
      clk_n = ~clk_n;
    end
  end

  // 156.25 MHz reference, offset 50 ps so its edges never land on a sample instant.
  initial begin
    ref_osc = 1'b0;
    #0.05;
    forever begin
      #3.2;
      ref_osc = ~ref_osc;
    end
  end

  assign ref_p = ref_force | ref_osc;
  assign ref_n = ref_force | ~ref_osc;

  mmcm_slave_test dut (
    .clk_in_300Mhz_p     (clk_p),
    .clk_in_300Mhz_n     (clk_n),
    .reset_in            (reset_in),
    .clk_in_156_25_mhz_p (ref_p),
    .clk_in_156_25_mhz_n (ref_n),
    .user_sma_master_sig (master_d),
    .user_sma_slave_sig  (slave_d)
  );

  mmcm_slave_test #(
    .ACC_W     (32),
    .PHASE_INC (64'h8000_0000),
    .START_DLY (4)
  ) dut_fast (
    .clk_in_300Mhz_p     (clk_p),
    .clk_in_300Mhz_n     (clk_n),
    .reset_in            (reset_in),
    .clk_in_156_25_mhz_p (ref_p),
    .clk_in_156_25_mhz_n (ref_n),
    .user_sma_master_sig (master_f),
    .user_sma_slave_sig  (slave_f)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Default-build master level k clk edges after reset_in release (hand-computed:
  // first MSB set after 15 updates, wrap after 30, next set after 45).
  function automatic logic def_master_exp(input int k, output logic valid);
    valid = 1'b1;
    case (k)
      1, 3, 17: def_master_exp = 1'b0;
      18, 32:   def_master_exp = 1'b1;
      33, 47:   def_master_exp = 1'b0;
      48:       def_master_exp = 1'b1;
      default: begin
        def_master_exp = 1'b0;
        valid          = 1'b0;
      end
    endcase
  endfunction

  // Release reset just after a clk edge, then check both builds edge by edge.
  task automatic release_run(input int pass);
    int   rises[$];
    int   falls[$];
    logic prev_m;
    logic exp_ref;
    logic exp_m;
    logic valid;
    int   per;
    int   hi;
    reset_in = 1'b0;
    prev_m   = 1'b0;
    for (int k = 1; k <= 1200; k++) begin
      @(posedge clk_p);
      #0.2;
      exp_ref = ref_p & ~ref_n;
      if (k <= 12) begin
        chk("fast_master", master_f, (k >= 4) ? (((k - 4) % 2) == 0) : 1'b0);
        chk("fast_slave", slave_f, (k >= 7) & exp_ref);
      end
      exp_m = def_master_exp(k, valid);
      if (valid) chk("def_master", master_d, exp_m);
      if (k >= 1018 && k <= 1040) chk("def_slave", slave_d, (k >= 1027) & exp_ref);
      if (!prev_m && master_d) rises.push_back(k);
      if (prev_m && !master_d) falls.push_back(k);
      prev_m = master_d;
    end
    chk("rise_count_ok", rises.size() >= 4, 1);
    chk("fall_count_ok", falls.size() >= 4, 1);
    if (rises.size() >= 4 && falls.size() >= 4) begin
      for (int i = 0; i < 3; i++) begin
        per = rises[i+1] - rises[i];
        hi  = falls[i] - rises[i];
        chk("master_period_ok", (per >= 29) && (per <= 31), 1);
        chk("master_high_ok", (hi >= 14) && (hi <= 16), 1);
      end
    end
    $display("release pass %0d: %0d master rises seen", pass, rises.size());
  endtask

  initial begin
    reset_in  = 1'b1;
    ref_force = 1'b0;

    // Reset held for 1 us: both outputs low throughout, accumulator clear.
    #0.5;
    chk("rst_master_t0", master_d, 0);
    chk("rst_slave_t0", slave_d, 0);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk_p);
      #0.2;
      chk("rst_master", master_d, 0);
      chk("rst_slave", slave_d, 0);
      chk("rst_master_f", master_f, 0);
      chk("rst_slave_f", slave_f, 0);
      chk("rst_acc", dut.u_nco.acc_reg, 0);
    end
    $display("reset hold done");

    chk("phase_inc_fn", phase_inc(10.0e6, 300.0e6, 32), 64'd143165577);
    chk("phase_inc_half", phase_inc(150.0e6, 300.0e6, 32), 64'h8000_0000);

    release_run(1);

    // Mid-run reset while the reference is high and the slave is enabled.
    for (int i = 0; i < 20 && !(ref_p & ~ref_n); i++) #0.5;
    chk("ref_high_found", ref_p & ~ref_n, 1);
    chk("slave_live", slave_d, 1);
    reset_in = 1'b1;
    #0.05;
    chk("midrst_master", master_d, 0);
    chk("midrst_slave", slave_d, 0);
    chk("midrst_master_f", master_f, 0);
    chk("midrst_slave_f", slave_f, 0);
    chk("midrst_en", dut.slave_en_reg, 0);
    chk("midrst_acc", dut.u_nco.acc_reg, 0);
    repeat (3) @(posedge clk_p);
    #0.2;
    chk("midrst_hold_slave", slave_d, 0);
    $display("mid-run reset applied");

    release_run(2);

    // Equal reference legs must gate the slave output off even when enabled.
    ref_force = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_p);
      #0.2;
      chk("ref_eq_slave", slave_d, 0);
      chk("ref_eq_slave_f", slave_f, 0);
    end
    ref_force = 1'b0;
    $display("equal-leg reference check done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
